// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the pipelined M:1 N-bit selector.
package mux_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned m);
        return sel < m;
    endfunction

endpackage

// File: rtl/mux_nsel_nbit.sv
// Combinational M:1 N-bit word selector; a select >= M yields word 0.
module mux_nsel_nbit #(
    parameter  int unsigned N = 32,
    parameter  int unsigned M = 4,
    localparam int unsigned S = $clog2(M)
) (
    input  logic [M*N-1:0] i_data,
    input  logic [S-1:0]   i_sel,
    output logic [N-1:0]   o_data_c
);

    always_comb begin
        o_data_c = i_data[N-1:0];
        for (int k = 0; k < int'(M); k++) begin
            if (i_sel == S'(k)) begin
                o_data_c = i_data[k*N +: N];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_nbit.sv
// Pipelined M:1 N-bit selector with a 2-entry skid buffer (registered output, flush).
// Optional select range check enabled by MUX_PIPE_SEL_CHECK_EN (adds out_err).
module mux_pipe_nbit
    import mux_pipe_pkg::*;
#(
    parameter  int unsigned N = 32,
    parameter  int unsigned M = 4,
    localparam int unsigned S = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M*N-1:0] in_data,
    input  logic [S-1:0]   in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           flush,
    output logic [N-1:0]   out_data,
    output logic [S-1:0]   out_sel,
`ifdef MUX_PIPE_SEL_CHECK_EN
    output logic           out_err,
`endif
    output logic           out_valid,
    input  logic           out_ready
);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [N-1:0] r_main_data;
    logic [S-1:0] r_main_sel;
    logic [N-1:0] r_skid_data;
    logic [S-1:0] r_skid_sel;
    logic [N-1:0] w_mux_data;
    logic [N-1:0] w_cap_data;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_load_main_in;
    logic         w_load_main_skid;
    logic         w_load_skid;

    mux_nsel_nbit #(.N(N), .M(M)) u_sel (
        .i_data   (in_data),
        .i_sel    (in_sel),
        .o_data_c (w_mux_data)
    );

`ifdef MUX_PIPE_SEL_CHECK_EN
    logic w_cap_err;
    logic r_main_err;
    logic r_skid_err;

    // Out-of-range selects capture zero and flag the beat.
    assign w_cap_err  = !sel_in_range(32'(in_sel), M);
    assign w_cap_data = w_cap_err ? '0 : w_mux_data;
    assign out_err    = r_main_err;
`else
    assign w_cap_data = w_mux_data;
`endif

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready   = (r_state != TWO) && !rst;
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main_data;
    assign out_sel    = r_main_sel;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
`ifdef MUX_PIPE_SEL_CHECK_EN
            r_main_err  <= 1'b0;
            r_skid_err  <= 1'b0;
`endif
        end else if (flush) begin
            r_state     <= EMPTY;
`ifdef MUX_PIPE_SEL_CHECK_EN
            r_main_err  <= 1'b0;
            r_skid_err  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main_data <= w_cap_data;
                r_main_sel  <= in_sel;
`ifdef MUX_PIPE_SEL_CHECK_EN
                r_main_err  <= w_cap_err;
`endif
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_sel  <= r_skid_sel;
`ifdef MUX_PIPE_SEL_CHECK_EN
                r_main_err  <= r_skid_err;
`endif
            end
            if (w_load_skid) begin
                r_skid_data <= w_cap_data;
                r_skid_sel  <= in_sel;
`ifdef MUX_PIPE_SEL_CHECK_EN
                r_skid_err  <= w_cap_err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_nbit.sv
// Directed bench for mux_pipe_nbit: an M=4 instance plus an M=3 instance for out-of-range selects.
module tb_mux_pipe_nbit;

    localparam int unsigned N  = 32;
    localparam int unsigned M  = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned M3 = 3;
    localparam int unsigned S3 = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            out_ready;
    logic [M*N-1:0]  in_data;
    logic [S-1:0]    in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    out_data;
    logic [S-1:0]    out_sel;
    logic            out_valid;
    logic [M3*N-1:0] in_data3;
    logic [S3-1:0]   in_sel3;
    logic            in_valid3;
    logic            in_ready3;
    logic [N-1:0]    out_data3;
    logic [S3-1:0]   out_sel3;
    logic            out_valid3;
`ifdef MUX_PIPE_SEL_CHECK_EN
    logic            out_err;
    logic            out_err3;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_pipe_nbit #(.N(N), .M(M)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef MUX_PIPE_SEL_CHECK_EN
        .out_err   (out_err),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_pipe_nbit #(.N(N), .M(M3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .flush     (flush),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
`ifdef MUX_PIPE_SEL_CHECK_EN
        .out_err   (out_err3),
`endif
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    function automatic logic [N-1:0] word(input int k);
        return 32'h1000_0000 + N'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < int'(M); k++) in_data[k*N +: N] = word(k);
        for (int k = 0; k < int'(M3); k++) in_data3[k*N +: N] = word(k);
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_sel = 2'd0;
        in_valid3 = 1'b0; in_sel3 = 2'd0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);

        // Reset held two cycles with a beat presented.
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_in_ready_hold", 64'(in_ready), 64'd0);
        end
        check("rst_out_valid3", 64'(out_valid3), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Streaming at full rate.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel = S'(k);
            cyc();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(word(k)));
            check("stream_sel", 64'(out_sel), 64'(k));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("stream_drain", 64'(out_valid), 64'd0);

        // Back-pressure fills the skid entry.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
        cyc();
        check("bp_first_data", 64'(out_data), 64'(word(2)));
        check("bp_first_ready", 64'(in_ready), 64'd1);
        in_sel = 2'd3;
        cyc();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_data", 64'(out_data), 64'(word(2)));
        in_sel = 2'd1;
        cyc();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'(word(2)));
        check("bp_hold_sel", 64'(out_sel), 64'd2);
        out_ready = 1'b1; in_valid = 1'b0;
        cyc();
        check("bp_skid_data", 64'(out_data), 64'(word(3)));
        check("bp_skid_sel", 64'(out_sel), 64'd3);
        check("bp_skid_ready", 64'(in_ready), 64'd1);
        cyc();
        check("bp_drain", 64'(out_valid), 64'd0);

        // Flush in TWO with a beat presented.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        cyc();
        in_sel = 2'd1;
        cyc();
        check("fl_two_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_sel = 2'd2;
        cyc();
        check("fl_two_valid", 64'(out_valid), 64'd0);
        check("fl_two_ready_after", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        check("fl_two_no_ghost", 64'(out_valid), 64'd0);

        // Flush in ONE discards a beat accepted-looking in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
        cyc();
        check("fl_one_loaded", 64'(out_data), 64'(word(3)));
        flush = 1'b1; in_sel = 2'd1;
        cyc();
        check("fl_one_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        check("fl_one_no_ghost", 64'(out_valid), 64'd0);

        // Reset and flush together: reset values win.
        in_valid = 1'b1; in_sel = 2'd3;
        cyc();
        check("rf_loaded", 64'(out_data), 64'(word(3)));
        rst = 1'b1; flush = 1'b1; in_sel = 2'd2;
        #1;
        check("rf_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("rf_valid", 64'(out_valid), 64'd0);
        check("rf_data", 64'(out_data), 64'd0);
        check("rf_sel", 64'(out_sel), 64'd0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        check("rf_ready_after", 64'(in_ready), 64'd1);

        // M=3 with out-of-range select, then an in-range beat.
        in_valid3 = 1'b1; in_sel3 = 2'd3;
        cyc();
        check("m3_oor_valid", 64'(out_valid3), 64'd1);
        check("m3_oor_sel", 64'(out_sel3), 64'd3);
`ifdef MUX_PIPE_SEL_CHECK_EN
        check("m3_oor_data", 64'(out_data3), 64'd0);
        check("m3_oor_err", 64'(out_err3), 64'd1);
`else
        check("m3_oor_data", 64'(out_data3), 64'(word(0)));
`endif
        in_sel3 = 2'd1;
        cyc();
        check("m3_in_data", 64'(out_data3), 64'(word(1)));
`ifdef MUX_PIPE_SEL_CHECK_EN
        check("m3_in_err", 64'(out_err3), 64'd0);
`endif
        in_valid3 = 1'b0;
        cyc();
        check("m3_drain", 64'(out_valid3), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
